// File: rtl/logisim_tick_generator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logisim_tick_generator_pkg
//  Description : Shared state encoding for the tick generator FSM.
//  Contents    : tick_state_e  - IDLE / RUN / STEP
//  Revision    : 1.0 - initial release
// ============================================================================
package logisim_tick_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } tick_state_e;

endpackage : logisim_tick_generator_pkg
`default_nettype wire

// File: rtl/logisim_tick_generator_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : logisim_tick_generator_tick_prescaler
//  Description : Prescaler counter with a loadable divisor register and a
//                ">=" terminal compare.
//  Ports       : clock       - system clock, rising edge
//                resetN      - asynchronous active-low reset
//                i_clear     - zero the prescaler at this edge
//                i_count_en  - advance the prescaler at this edge
//                i_load      - capture i_divisor into the divisor register
//                i_divisor   - new divisor value
//                o_terminal  - prescaler has reached (or passed) the divisor
//  Revision    : 1.0 - initial release
// ============================================================================
module logisim_tick_generator_tick_prescaler #(
    parameter int                     counterBits    = 16,
    parameter logic [counterBits-1:0] defaultDivisor = '0
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   i_clear,
    input  logic                   i_count_en,
    input  logic                   i_load,
    input  logic [counterBits-1:0] i_divisor,
    output logic                   o_terminal
);

    localparam logic [counterBits-1:0] c_one = counterBits'(1);

    logic [counterBits-1:0] prescaler_q, prescaler_d;
    logic [counterBits-1:0] div_reg_q,   div_reg_d;

    // ">=" rather than "==" so a divisor lowered mid-count terminates at the
    // next edge instead of wrapping through the whole counter range. The
    // compare always sees the old divisor during a load edge.
    assign o_terminal = (prescaler_q >= div_reg_q);

    always_comb begin
        prescaler_d = prescaler_q;
        div_reg_d   = div_reg_q;
        // The FSM only advances while not terminal, so prescaler_q < div_reg_q
        // here and the increment can never overflow.
        if (i_clear) begin
            prescaler_d = '0;
        end else if (i_count_en) begin
            prescaler_d = prescaler_q + c_one;
        end
        if (i_load) begin
            div_reg_d = i_divisor;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            prescaler_q <= '0;
            div_reg_q   <= defaultDivisor;
        end else begin
            prescaler_q <= prescaler_d;
            div_reg_q   <= div_reg_d;
        end
    end

endmodule : logisim_tick_generator_tick_prescaler
`default_nettype wire

// File: rtl/logisim_tick_generator.sv
`default_nettype none
// ============================================================================
//  Module      : logisim_tick_generator
//  Description : Programmable tick strobe source with free-run, single-step
//                and stopped modes, plus a debug tick counter.
//  Ports       : clock          - system clock, rising edge
//                resetN         - asynchronous active-low reset
//                run            - level, 1 = free-running ticks
//                step           - rising edge requests one prescaled tick
//                divisor        - new divisor (period = divisor+1 clocks)
//                divisorLoad    - capture divisor at this edge
//                tickCountClear - zero tickCount at this edge
//                tick           - registered one-cycle strobe
//                tickCount      - ticks issued, wraps
//                running        - FSM is in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module logisim_tick_generator
    import logisim_tick_generator_pkg::*;
#(
    parameter int                     counterBits    = 16,
    parameter int                     countBits      = 16,
    parameter logic [counterBits-1:0] defaultDivisor = '0
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   run,
    input  logic                   step,
    input  logic [counterBits-1:0] divisor,
    input  logic                   divisorLoad,
    input  logic                   tickCountClear,
    output logic                   tick,
    output logic [countBits-1:0]   tickCount,
    output logic                   running
);

    localparam logic [countBits-1:0] c_count_one = countBits'(1);

    tick_state_e            state_q,      state_d;
    logic                   tick_q,       tick_d;
    logic [countBits-1:0]   tick_count_q, tick_count_d;
    logic                   running_q,    running_d;
    logic                   step_prev_q,  step_prev_d;

    logic w_step_edge;
    logic w_terminal;
    logic w_presc_clear;
    logic w_presc_inc;

    assign w_step_edge = step & ~step_prev_q;

    logisim_tick_generator_tick_prescaler #(
        .counterBits    (counterBits),
        .defaultDivisor (defaultDivisor)
    ) u_tick_prescaler (
        .clock      (clock),
        .resetN     (resetN),
        .i_clear    (w_presc_clear),
        .i_count_en (w_presc_inc),
        .i_load     (divisorLoad),
        .i_divisor  (divisor),
        .o_terminal (w_terminal)
    );

    always_comb begin
        state_d       = state_q;
        tick_d        = 1'b0;
        w_presc_clear = 1'b0;
        w_presc_inc   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // run wins; a coincident step edge is dropped
                if (run) begin
                    state_d       = ST_RUN;
                    w_presc_clear = 1'b1;
                end else if (w_step_edge) begin
                    state_d       = ST_STEP;
                    w_presc_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    // partial count is abandoned
                    state_d       = ST_IDLE;
                    w_presc_clear = 1'b1;
                end else if (w_terminal) begin
                    tick_d        = 1'b1;
                    w_presc_clear = 1'b1;
                end else begin
                    w_presc_inc   = 1'b1;
                end
            end
            ST_STEP: begin
                // switching to RUN keeps the count already accumulated
                if (run) begin
                    state_d = ST_RUN;
                end
                if (w_terminal) begin
                    tick_d        = 1'b1;
                    w_presc_clear = 1'b1;
                    if (!run) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    w_presc_inc   = 1'b1;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                w_presc_clear = 1'b1;
            end
        endcase

        // clear beats a coincident tick
        if (tickCountClear) begin
            tick_count_d = '0;
        end else if (tick_d) begin
            tick_count_d = tick_count_q + c_count_one;
        end else begin
            tick_count_d = tick_count_q;
        end

        running_d   = (state_d == ST_RUN);
        step_prev_d = step;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
            running_q    <= 1'b0;
            step_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            running_q    <= running_d;
            step_prev_q  <= step_prev_d;
        end
    end

    assign tick      = tick_q;
    assign tickCount = tick_count_q;
    assign running   = running_q;

endmodule : logisim_tick_generator
`default_nettype wire

// File: tb/tb_logisim_tick_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logisim_tick_generator
//  Description : Self-checking bench for logisim_tick_generator. A mode-level
//                reference model is compared against the DUT on every falling
//                edge; directed sequences add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logisim_tick_generator;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [15:0] divisor = 16'd0;
    logic        divisorLoad = 1'b0;
    logic        tickCountClear = 1'b0;
    logic        tick;
    logic [15:0] tickCount;
    logic        running;

    int n_cmp = 0;
    int n_bad = 0;

    logisim_tick_generator #(
        .counterBits    (16),
        .countBits      (16),
        .defaultDivisor (16'd0)
    ) dut (
        .clock          (clock),
        .resetN         (resetN),
        .run            (run),
        .step           (step),
        .divisor        (divisor),
        .divisorLoad    (divisorLoad),
        .tickCountClear (tickCountClear),
        .tick           (tick),
        .tickCount      (tickCount),
        .running        (running)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Mode 0 = stopped, 1 = free-running, 2 = one-shot.
    // "waited" is the number of edges spent in the current active period;
    // a tick is due once waited has reached the divisor in effect.
    // ------------------------------------------------------------------
    int          m_mode = 0;
    int          m_waited = 0;
    int unsigned m_div = 0;
    bit          m_tick = 0;
    int unsigned m_count = 0;
    bit          m_running = 0;
    bit          m_prev = 0;
    bit          m_req;
    bit          m_due;

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            m_mode = 0; m_waited = 0; m_div = 0; m_tick = 0;
            m_count = 0; m_running = 0; m_prev = 0;
        end else begin
            m_req  = step && !m_prev;
            m_due  = (m_waited >= int'(m_div));
            m_tick = 0;
            if (m_mode == 0) begin
                if (run)        begin m_mode = 1; m_waited = 0; end
                else if (m_req) begin m_mode = 2; m_waited = 0; end
            end else if (m_mode == 1 && !run) begin
                m_mode = 0; m_waited = 0;
            end else begin
                // active period: free-running, or one-shot possibly promoted
                if (run) m_mode = 1;
                if (m_due) begin
                    m_tick = 1; m_waited = 0;
                    if (!run) m_mode = 0;
                end else begin
                    m_waited = m_waited + 1;
                end
            end
            if (tickCountClear) m_count = 0;
            else if (m_tick)    m_count = (m_count + 1) % 65536;
            m_running = (m_mode == 1);
            m_prev    = step;
            if (divisorLoad) m_div = divisor;
        end
    end

    always @(negedge clock) begin
        check("model_tick",      tick,      m_tick);
        check("model_tickCount", tickCount, m_count);
        check("model_running",   running,   m_running);
    end

    // ------------------------------------------------------------------
    // Directed sequences with literal expectations
    // ------------------------------------------------------------------
    logic [9:0] step_pat;

    initial begin
        // reset state before any clock edge
        #2;
        check("rst_tick", tick, 0);
        check("rst_count", tickCount, 0);
        check("rst_running", running, 0);
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);

        // free-run at divisor 0: tick every cycle after entry
        run = 1'b1;
        repeat (11) @(negedge clock);
        check("run0_count10", tickCount, 10);
        check("run0_running", running, 1);
        check("run0_tick", tick, 1);

        // stop, load divisor 3, clear count
        run = 1'b0;
        @(negedge clock);
        check("stop_tick", tick, 0);
        check("stop_running", running, 0);
        divisor = 16'd3; divisorLoad = 1'b1;
        @(negedge clock);
        divisorLoad = 1'b0; tickCountClear = 1'b1;
        @(negedge clock);
        tickCountClear = 1'b0;
        check("clr_count", tickCount, 0);

        // run with divisor 3: tick on every 4th edge after entry
        run = 1'b1;
        @(negedge clock);
        check("div3_entry_tick", tick, 0);
        check("div3_entry_running", running, 1);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clock);
            check("div3_pattern", tick, (i % 4 == 0) ? 1 : 0);
        end
        // drop run mid-count
        run = 1'b0;
        @(negedge clock);
        check("div3_drop_tick", tick, 0);
        check("div3_drop_running", running, 0);
        repeat (10) begin
            @(negedge clock);
            check("div3_idle_tick", tick, 0);
        end
        check("div3_count", tickCount, 2);

        // single step with divisor 2, step held high for 5 cycles
        divisor = 16'd2; divisorLoad = 1'b1;
        @(negedge clock);
        divisorLoad = 1'b0;
        step = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            check("step_hold_tick", tick, (i == 4) ? 1 : 0);
            check("step_hold_running", running, 0);
        end
        step = 1'b0;
        @(negedge clock);
        check("step_hold_count", tickCount, 3);

        // second step edge during STEP is ignored
        step_pat = 10'b00_0000_0101;
        for (int i = 1; i <= 9; i++) begin
            step = step_pat[i-1];
            @(negedge clock);
            check("step_again_tick", tick, (i == 4) ? 1 : 0);
        end
        step = 1'b0;
        check("step_again_count", tickCount, 4);

        // divisor 100 running, lower to 10 at about half-way
        divisor = 16'd100; divisorLoad = 1'b1;
        @(negedge clock);
        divisorLoad = 1'b0;
        run = 1'b1;
        @(negedge clock);
        repeat (50) @(negedge clock);
        check("div100_no_tick_yet", tick, 0);
        divisor = 16'd10; divisorLoad = 1'b1;
        @(negedge clock);
        divisorLoad = 1'b0;
        check("div_lower_load_edge", tick, 0);
        @(negedge clock);
        check("div_lower_fire", tick, 1);
        for (int i = 1; i <= 22; i++) begin
            @(negedge clock);
            check("div10_period", tick, (i % 11 == 0) ? 1 : 0);
        end

        // divisor 0, clear coincident with a tick, then full wrap
        divisor = 16'd0; divisorLoad = 1'b1;
        @(negedge clock);
        divisorLoad = 1'b0;
        @(negedge clock);
        check("div0_tick", tick, 1);
        tickCountClear = 1'b1;
        @(negedge clock);
        tickCountClear = 1'b0;
        check("clr_with_tick_tick", tick, 1);
        check("clr_with_tick_count", tickCount, 0);
        repeat (65535) @(negedge clock);
        check("wrap_max", tickCount, 16'hFFFF);
        @(negedge clock);
        check("wrap_zero", tickCount, 0);
        check("wrap_tick", tick, 1);

        // async reset mid-run with tick high; divisor 5 loaded at that edge
        divisor = 16'd5; divisorLoad = 1'b1;
        @(posedge clock);
        #2;
        check("pre_rst_tick", tick, 1);
        check("pre_rst_running", running, 1);
        #1 resetN = 1'b0;
        divisorLoad = 1'b0;
        #1;
        check("async_rst_tick", tick, 0);
        check("async_rst_count", tickCount, 0);
        check("async_rst_running", running, 0);
        @(negedge clock);
        resetN = 1'b1;
        // run still high: re-enter RUN, default divisor 0 gives a tick every cycle
        @(negedge clock);
        check("post_rst_entry_tick", tick, 0);
        check("post_rst_running", running, 1);
        @(negedge clock);
        check("post_rst_tick1", tick, 1);
        @(negedge clock);
        check("post_rst_tick2", tick, 1);
        check("post_rst_count", tickCount, 2);
        run = 1'b0;
        repeat (2) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_logisim_tick_generator
`default_nettype wire
